// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin output scheduler.
// Holds the FSM state type, default sizes and small sizing/one-hot helpers.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP
    } state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        return 32'(1) << idx;
    endfunction

    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 2;
    localparam int BURST_DEF  = 3;
    localparam int GAP_DEF    = 1;
    localparam int BEAT_W_DEF = cnt_w(BURST_DEF + 1);
    localparam int GAP_W_DEF  = cnt_w(GAP_DEF + 1);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or
// above ptr_i, wrapping. Ports: eligible_i, ptr_i -> win_o, found_o.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = cnt_w(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   win_o,
    output logic            found_o
);

    int j;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found_o && eligible_i[j]) begin
                found_o = 1'b1;
                win_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_output_scheduler.sv
// Round-robin scheduler sharing one registered output channel among NREQ
// requesters with fixed bursts, forced-zero gaps and a per-requester mask.
// Ports: clk, reset (async active-low), req, req_mask, req_data ->
//        grant, owner_idx, data_out, data_valid, busy.
module rr_output_scheduler
    import rr_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int W     = W_DEF,
    parameter int BURST = BURST_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_mask,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] owner_idx,
    output logic [W-1:0]            data_out,
    output logic                    data_valid,
    output logic                    busy
);

    localparam int IW = cnt_w(NREQ);
    localparam int BW = cnt_w(BURST + 1);
    localparam int GW = cnt_w(GAP + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;

    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   win;
    logic            found;
    logic [IW-1:0]   ptr_nxt;
    logic            own_ok;

    assign eligible = req & ~req_mask;
    assign own_ok   = eligible[owner_q];
    assign ptr_nxt  = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .win_o      (win),
        .found_o    (found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        // Channel is forced to zero unless a beat is issued below.
        data_d  = '0;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d = NREQ'(onehot(int'(win)));
                    owner_d = win;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (own_ok) begin
                    data_d  = req_data[int'(owner_q)*W +: W];
                    valid_d = 1'b1;
                    beat_d  = beat_q + BW'(1);
                end
                if (!own_ok || int'(beat_q) == BURST - 1) begin
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                    beat_d  = '0;
                    gap_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                grant_d = '0;
                if (int'(gap_q) == GAP - 1) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign grant      = grant_q;
    assign owner_idx  = owner_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
